// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// UART_PARITY_EN adds the PARITY state and sets STATUS bit 3.
package uart_pkg;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} uart_state_e;
  localparam logic ParityEn = 1'b1;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;
  localparam logic ParityEn = 1'b0;
`endif

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_PAR     = 3;
  localparam int unsigned ST_CNT_LSB = 4;

  localparam int unsigned OFF_TXDATA = 0;
  localparam int unsigned OFF_STATUS = 4;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the TX path; caller must not push when full or pop when empty.
module uart_tx_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PtrW'(1);
      if (pop_i)  rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS decode, TX FIFO and 8N1 serializer.
// Define UART_PARITY_EN to insert an even-parity bit before the stop bit.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_waddr,
  input  logic        bus_we,
  input  logic [31:0] bus_wdata,
  input  logic [31:0] bus_raddr,
  input  logic        bus_re,
  output logic [31:0] bus_rdata,
  output logic        bus_sel,
  output logic        uart_tx,
  output logic        irq_txempty
);

  localparam int unsigned BaudW = $clog2(CLK_DIV);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] TxAddr     = BASE_ADDR + 32'(OFF_TXDATA);
  localparam logic [31:0] StatusAddr = BASE_ADDR + 32'(OFF_STATUS);
  localparam logic [BaudW-1:0] BaudLoad = BaudW'(CLK_DIV - 1);

  logic            wr_tx, wr_status, rd_tx, rd_status;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_rdata;
  logic [CntW-1:0] fifo_count;

  uart_state_e      state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ovf_q, ovf_d;
`ifdef UART_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic        baud_done, busy;
  logic [7:0]  cnt_ext;
  logic [2:0]  cnt_field;
  logic [31:0] status;
  logic        unused_wdata;

  assign wr_tx     = bus_we && (bus_waddr == TxAddr);
  assign wr_status = bus_we && (bus_waddr == StatusAddr);
  assign rd_tx     = (bus_raddr == TxAddr);
  assign rd_status = (bus_raddr == StatusAddr);

  // Full is the pre-edge state, so a same-cycle pop never makes room.
  assign fifo_push = wr_tx && !fifo_full;

  assign unused_wdata = ^bus_wdata[31:8];

  uart_tx_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .wdata_i (bus_wdata[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign baud_done = (baud_q == '0);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
`ifdef UART_PARITY_EN
    parity_d  = parity_q;
`endif

    if (state_q != StIdle) begin
      baud_d = baud_done ? BaudLoad : baud_q - BaudW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          baud_d   = BaudLoad;
          state_d  = StStart;
`ifdef UART_PARITY_EN
          parity_d = ^fifo_rdata;
`endif
        end
      end
      StStart: begin
        if (baud_done) begin
          state_d   = StData;
          bit_idx_d = 3'd0;
        end
      end
      StData: begin
        if (baud_done) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (baud_done) state_d = StStop;
      end
`endif
      StStop: begin
        if (baud_done) begin
          // Back-to-back frames: the next start bit follows the stop bit directly.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = StStart;
`ifdef UART_PARITY_EN
            parity_d = ^fifo_rdata;
`endif
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // The line is registered, so it follows the state being entered.
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef UART_PARITY_EN
      StParity: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (wr_status && bus_wdata[2]) ovf_d = 1'b0;
    if (wr_tx && fifo_full)        ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
`ifdef UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
`ifdef UART_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign busy      = !fifo_empty || (state_q != StIdle);
  assign cnt_ext   = 8'(fifo_count);
  assign cnt_field = (cnt_ext > 8'd7) ? 3'd7 : cnt_ext[2:0];

  always_comb begin
    status                    = '0;
    status[ST_BUSY]           = busy;
    status[ST_FULL]           = fifo_full;
    status[ST_OVF]            = ovf_q;
    status[ST_PAR]            = ParityEn;
    status[ST_CNT_LSB +: 3]   = cnt_field;

    bus_rdata = '0;
    if (bus_re && rd_status) bus_rdata = status;
  end

  assign bus_sel     = bus_re && (rd_tx || rd_status);
  assign uart_tx     = tx_q;
  assign irq_txempty = fifo_empty && (state_q == StIdle);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-timeline model checked every cycle plus literal expectations.
module tb_mmio_uart_tx;

  localparam int unsigned DIV   = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0001_0004;
  localparam logic [31:0] STAT  = 32'h0001_0008;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
  localparam logic PAR_EN = 1'b1;
`else
  localparam int NBITS = 10;
  localparam logic PAR_EN = 1'b0;
`endif
  localparam int FRAME_LEN = NBITS * DIV;

  logic        clk, rst;
  logic [31:0] bus_waddr, bus_wdata, bus_raddr, bus_rdata;
  logic        bus_we, bus_re, bus_sel, uart_tx, irq_txempty;

  int checks = 0;
  int errors = 0;

  mmio_uart_tx #(
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_waddr   (bus_waddr),
    .bus_we      (bus_we),
    .bus_wdata   (bus_wdata),
    .bus_raddr   (bus_raddr),
    .bus_re      (bus_re),
    .bus_rdata   (bus_rdata),
    .bus_sel     (bus_sel),
    .uart_tx     (uart_tx),
    .irq_txempty (irq_txempty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Model: pending bytes, the byte on the line and how many cycles into its frame we are.
  logic [7:0] m_fifo[$];
  logic [7:0] m_byte;
  logic       m_active = 1'b0;
  int         m_pos = 0;
  logic       m_ovf = 1'b0;
  logic       check_en = 1'b0;

  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef UART_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_status();
    int n;
    logic [31:0] s;
    n = m_fifo.size();
    s = '0;
    s[6:4] = (n > 7) ? 3'd7 : 3'(n);
    s[3]   = PAR_EN;
    s[2]   = m_ovf;
    s[1]   = (n == DEPTH);
    s[0]   = (n > 0) || m_active;
    return s;
  endfunction

  always @(posedge clk) begin
    int pre;
    if (rst) begin
      m_fifo.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_ovf    = 1'b0;
      check_en = 1'b1;
    end else begin
      pre = m_fifo.size();
      if (m_active) begin
        m_pos++;
        if (m_pos == FRAME_LEN) m_active = 1'b0;
      end
      if (!m_active && pre > 0) begin
        m_byte   = m_fifo.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end
      if (bus_we && bus_waddr == STAT && bus_wdata[2]) m_ovf = 1'b0;
      if (bus_we && bus_waddr == BASE) begin
        if (pre < DEPTH) m_fifo.push_back(bus_wdata[7:0]);
        else m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic        e_tx, e_sel;
    logic [31:0] e_rd;
    if (check_en) begin
      e_tx  = m_active ? frame_bit(m_byte, m_pos / DIV) : 1'b1;
      e_sel = bus_re && (bus_raddr == BASE || bus_raddr == STAT);
      e_rd  = (bus_re && bus_raddr == STAT) ? m_status() : 32'h0;
      chk("model_tx", {31'b0, uart_tx}, {31'b0, e_tx});
      chk("model_irq", {31'b0, irq_txempty}, {31'b0, !m_active && m_fifo.size() == 0});
      chk("model_sel", {31'b0, bus_sel}, {31'b0, e_sel});
      chk("model_rdata", bus_rdata, e_rd);
    end
  end

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus_waddr = addr;
    bus_wdata = data;
    bus_we    = 1'b1;
    @(posedge clk);
    #1;
    bus_we    = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data, output logic sel);
    bus_raddr = addr;
    bus_re    = 1'b1;
    @(negedge clk);
    #1;
    data   = bus_rdata;
    sel    = bus_sel;
    bus_re = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    logic        s;
    logic [10:0] bits55;
    logic [31:0] par;

    par = PAR_EN ? 32'h8 : 32'h0;
`ifdef UART_PARITY_EN
    bits55 = 11'b10010101010;
`else
    bits55 = 11'b01010101010;
`endif
    rst = 1'b1; bus_we = 1'b0; bus_re = 1'b0;
    bus_waddr = '0; bus_wdata = '0; bus_raddr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset and idle
    @(negedge clk);
    chk("reset_tx", {31'b0, uart_tx}, 32'd1);
    chk("reset_irq", {31'b0, irq_txempty}, 32'd1);
    chk("reset_sel_no_re", {31'b0, bus_sel}, 32'd0);
    chk("reset_rdata_no_re", bus_rdata, 32'd0);
    rd(STAT, v, s);
    chk("reset_status", v, par);
    rd(BASE, v, s);
    chk("txdata_read_zero", v, 32'd0);
    chk("txdata_sel", {31'b0, s}, 32'd1);
    rd(BASE + 32'd8, v, s);
    chk("outside_sel", {31'b0, s}, 32'd0);
    repeat (4) @(posedge clk);
    #1;

    // Single byte 0x55: line falls after the pop edge, one level per DIV cycles
    wr(BASE, 32'h55);
    @(negedge clk);
    chk("tx_high_before_pop", {31'b0, uart_tx}, 32'd1);
    for (int k = 0; k < NBITS; k++) begin
      @(negedge clk);
      chk("frame55_bit", {31'b0, uart_tx}, {31'b0, bits55[k]});
      if (k < NBITS - 1) repeat (3) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("irq_low_last_cycle", {31'b0, irq_txempty}, 32'd0);
    @(negedge clk);
    chk("irq_high_after_frame", {31'b0, irq_txempty}, 32'd1);
    repeat (3) @(posedge clk);
    #1;

    // Three back-to-back bytes
    wr(BASE, 32'hA1);
    wr(BASE, 32'hB2);
    wr(BASE, 32'hC3);
    rd(STAT, v, s);
    chk("b2b_count2", v, 32'h21 | par);
    repeat (FRAME_LEN - 1) @(posedge clk);
    rd(STAT, v, s);
    chk("b2b_count1", v, 32'h11 | par);
    chk("b2b_no_gap_start", {31'b0, uart_tx}, 32'd0);
    repeat (FRAME_LEN) @(posedge clk);
    rd(STAT, v, s);
    chk("b2b_count0", v, 32'h01 | par);
    repeat (FRAME_LEN + 5) @(posedge clk);
    #1;
    chk("b2b_drained_irq", {31'b0, irq_txempty}, 32'd1);

    // Overflow: six writes in six cycles with four entries
    for (int i = 0; i < 5; i++) wr(BASE, 32'h11 + i);
    rd(STAT, v, s);
    chk("ovf_full_status", v, 32'h43 | par);
    wr(BASE, 32'h16);
    rd(STAT, v, s);
    chk("ovf_set_status", v, 32'h47 | par);
    wr(STAT, 32'hFFFF_FFFB);
    rd(STAT, v, s);
    chk("ovf_not_cleared_bit2_0", v, 32'h47 | par);
    wr(STAT, 32'h4);
    rd(STAT, v, s);
    chk("ovf_cleared", v, 32'h43 | par);
    repeat (5 * FRAME_LEN + 10) @(posedge clk);
    #1;

    // Reset in the middle of data bit 3 of 0xA5 (bit 3 is 0)
    wr(BASE, 32'hA5);
    repeat (18) @(posedge clk);
    @(negedge clk);
    chk("midframe_bit3_low", {31'b0, uart_tx}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midframe_reset_tx", {31'b0, uart_tx}, 32'd1);
    chk("midframe_reset_irq", {31'b0, irq_txempty}, 32'd1);
    rd(STAT, v, s);
    chk("midframe_reset_status", v, par);
    wr(BASE, 32'h96);
    repeat (FRAME_LEN + 10) @(posedge clk);
    #1;

`ifdef UART_PARITY_EN
    // 0x07 has three ones, so the even-parity bit is 1
    wr(BASE, 32'h07);
    repeat (34) @(negedge clk);
    chk("par07_data_bit7", {31'b0, uart_tx}, 32'd0);
    repeat (4) @(negedge clk);
    chk("par07_parity_bit", {31'b0, uart_tx}, 32'd1);
    repeat (FRAME_LEN) @(posedge clk);
    #1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
